mem_loader: RTL

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_loader.sv
// mem_loader: receives a little-endian byte stream (4-byte word count N followed
// by N data words) and writes the words into instruction memory from address 0,
// holding the CPU in reset while the load is in progress.
// Optional build macro: LOADER_CHECKSUM_EN adds a trailing 4-byte checksum that
// must equal the mod-2^32 sum of all data words for the load to end in DONE.
module mem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_din,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Word index and count carry one extra bit so that N = 2^ADDR_W terminates
  // instead of aliasing back to address 0.
  localparam int          IDX_W = ADDR_W + 1;
  localparam logic [32:0] LIMIT = 33'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CHK   = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        word_q, word_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]        sum_q, sum_d;
`endif

  logic               s_ready_q, s_ready_d;
  logic               im_we_q, im_we_d;
  logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
  logic [31:0]        im_din_q, im_din_d;
  logic               cpu_rst_n_q, cpu_rst_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               xfer;
  logic               last_byte;
  logic [31:0]        full_word;
  logic [IDX_W-1:0]   idx_inc;

  assign s_ready   = s_ready_q;
  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_din    = im_din_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  // Next-state, byte assembly and registered-output decode.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    im_addr_d  = im_addr_q;
    im_din_d   = im_din_q;

    // A byte moves only when the source offers it and our registered ready is up.
    xfer      = s_valid && s_ready_q;
    // Shifting in from the top leaves the first byte in [7:0] after four bytes.
    full_word = {s_data, word_q[31:8]};
    last_byte = xfer && (byte_cnt_q == 2'd3);
    idx_inc   = idx_q + IDX_W'(1);

    if (xfer) begin
      word_d     = full_word;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          idx_d      = '0;
          byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      S_LEN: begin
        if (last_byte) begin
          if (full_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, full_word} > LIMIT) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
            cnt_d   = full_word[IDX_W-1:0];
          end
        end
      end
      S_DATA: begin
        if (last_byte) begin
          state_d   = S_WRITE;
          im_addr_d = idx_q[ADDR_W-1:0];
          im_din_d  = full_word;
        end
      end
      S_WRITE: begin
        idx_d = idx_inc;
`ifdef LOADER_CHECKSUM_EN
        sum_d = sum_q + im_din_q;
`endif
        if (idx_inc == cnt_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (last_byte) begin
          state_d = (full_word == sum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    s_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    if (state_d == S_CHK) begin
      s_ready_d = 1'b1;
    end
`endif
    busy_d      = s_ready_d || (state_d == S_WRITE);
    im_we_d     = (state_d == S_WRITE);
    cpu_rst_n_d = (state_d == S_IDLE) || (state_d == S_DONE);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
  end

  // Control state and all outputs; reset forces IDLE with every output low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      idx_q       <= '0;
      s_ready_q   <= 1'b0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_din_q    <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      idx_q       <= idx_d;
      s_ready_q   <= s_ready_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_din_q    <= im_din_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Datapath holding registers; start re-initialises what matters, so no reset.
  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    word_q <= word_d;
`ifdef LOADER_CHECKSUM_EN
    sum_q  <= sum_d;
`endif
  end

endmodule
